// File: rtl/sysop_unit.sv
// sysop_unit -- execute-side front end for SYSTEM-opcode instructions.
//
// Accepts one SYSTEM instruction per handshake. It decodes ECALL, MRET and the
// six CSRR* forms into a cause/tval/wdata request for the downstream csr block.
// A CSR op captures the old CSR value and writes it back to the register file.
// ECALL/MRET wait for the csr trap pulse and forward it to fetch as a redirect.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          instruction handshake (in_ready == state IDLE)
//   inst, in_pc, rs1_data      instruction word, its PC, rs1 operand
//   flush                      pipeline kill (only suppresses the writeback)
//   csr_pc/csr_cause/csr_tval/csr_wdata   request to csr, driven during ISSUE
//   csr_rdata                  old CSR value, sampled only in ISSUE
//   trap_en/trap_pc            trap response from csr
//   wb_valid/wb_rd/wb_data     register-file writeback
//   redirect_en/redirect_pc    fetch redirect
//   illegal                    one-cycle pulse on an unsupported encoding
//   timeout_err                one-cycle pulse on trap timeout
//
// Configuration macro: SYSOP_TRAP_TIMEOUT_EN
//   When defined, WAIT_TRAP gives up after TRAP_TIMEOUT cycles without
//   trap_en and pulses timeout_err. When undefined, WAIT_TRAP waits forever
//   and timeout_err is tied to 0.

module sysop_unit #(
    parameter int TRAP_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [63:0] in_pc,
    input  logic [63:0] rs1_data,
    input  logic        flush,
    output logic [63:0] csr_pc,
    output logic [4:0]  csr_cause,
    output logic [63:0] csr_tval,
    output logic [63:0] csr_wdata,
    input  logic [63:0] csr_rdata,
    input  logic        trap_en,
    input  logic [63:0] trap_pc,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        redirect_en,
    output logic [63:0] redirect_pc,
    output logic        illegal,
    output logic        timeout_err
);

    localparam logic [4:0] SYSOP_NONE  = 5'd0;
    localparam logic [4:0] SYSOP_CSR_W = 5'd1;
    localparam logic [4:0] SYSOP_CSR_S = 5'd2;
    localparam logic [4:0] SYSOP_CSR_C = 5'd3;
    localparam logic [4:0] SYSOP_ECALL = 5'd4;
    localparam logic [4:0] SYSOP_RET   = 5'd5;

    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WB        = 2'd2,
        WAIT_TRAP = 2'd3
    } state_t;

    // Map an instruction word to its csr cause; SYSOP_NONE marks it illegal.
    function automatic logic [4:0] decode_cause(input logic [31:0] w);
        logic [4:0] c;
        c = SYSOP_NONE;
        if (w[6:0] != OPC_SYSTEM) begin
            c = SYSOP_NONE;
        end else begin
            case (w[14:12])
                3'b000: begin
                    if (w[31:20] == 12'h000) begin
                        c = SYSOP_ECALL;
                    end else if (w[31:20] == 12'h302) begin
                        c = SYSOP_RET;
                    end else begin
                        c = SYSOP_NONE;
                    end
                end
                3'b001, 3'b101: c = SYSOP_CSR_W;
                3'b010, 3'b110: c = SYSOP_CSR_S;
                3'b011, 3'b111: c = SYSOP_CSR_C;
                default:        c = SYSOP_NONE;
            endcase
        end
        return c;
    endfunction

    // True for the three CSR read-modify-write causes.
    function automatic logic is_csr_op(input logic [4:0] c);
        return (c == SYSOP_CSR_W) || (c == SYSOP_CSR_S) || (c == SYSOP_CSR_C);
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic        accept_s;
    logic [4:0]  dec_cause_s;
    logic [63:0] dec_wdata_s;
    logic        to_expired_s;

    logic [4:0]  cause_r;
    logic [11:0] tval_r;
    logic [63:0] wdata_r;
    logic [63:0] pc_r;
    logic [4:0]  rd_r;
    logic [63:0] rdata_r;
    logic        illegal_r;

    assign in_ready    = (state_r == IDLE);
    assign accept_s    = in_valid && in_ready;
    assign dec_cause_s = decode_cause(inst);
    // funct3[2] selects the immediate forms, whose operand is the rs1 field.
    assign dec_wdata_s = !is_csr_op(dec_cause_s) ? 64'd0 :
                         inst[14] ? {59'd0, inst[19:15]} : rs1_data;
    assign illegal     = illegal_r;

`ifdef SYSOP_TRAP_TIMEOUT_EN
    logic [31:0] to_cnt_r;

    // Wait-cycle counter: zeroed while in ISSUE so it starts clean on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= 32'd0;
        end else if (state_r == ISSUE) begin
            to_cnt_r <= 32'd0;
        end else if (state_r == WAIT_TRAP) begin
            to_cnt_r <= to_cnt_r + 32'd1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign to_expired_s = (to_cnt_r == 32'(TRAP_TIMEOUT - 1));
    assign timeout_err  = (state_r == WAIT_TRAP) && !trap_en && to_expired_s;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = (TRAP_TIMEOUT == 0);
    assign to_expired_s = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Latch the decoded request on accept; illegal encodings load too but never issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_r <= SYSOP_NONE;
            tval_r  <= 12'd0;
            wdata_r <= 64'd0;
            pc_r    <= 64'd0;
            rd_r    <= 5'd0;
        end else if (accept_s) begin
            cause_r <= dec_cause_s;
            tval_r  <= inst[31:20];
            wdata_r <= dec_wdata_s;
            pc_r    <= in_pc;
            rd_r    <= inst[11:7];
        end else begin
            cause_r <= cause_r;
            tval_r  <= tval_r;
            wdata_r <= wdata_r;
            pc_r    <= pc_r;
            rd_r    <= rd_r;
        end
    end

    // Old CSR value, captured at the edge where the csr write commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 64'd0;
        end else if (state_r == ISSUE) begin
            rdata_r <= csr_rdata;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Illegal pulse: one cycle after accepting an unsupported encoding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= accept_s && (dec_cause_s == SYSOP_NONE);
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state_s = state_r;
        csr_pc       = 64'd0;
        csr_cause    = SYSOP_NONE;
        csr_tval     = 64'd0;
        csr_wdata    = 64'd0;
        wb_valid     = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = 64'd0;
        redirect_en  = 1'b0;
        redirect_pc  = 64'd0;
        case (state_r)
            IDLE: begin
                if (accept_s && (dec_cause_s != SYSOP_NONE)) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                csr_pc    = pc_r;
                csr_cause = cause_r;
                csr_tval  = {52'd0, tval_r};
                csr_wdata = wdata_r;
                if (is_csr_op(cause_r)) begin
                    next_state_s = WB;
                end else begin
                    next_state_s = WAIT_TRAP;
                end
            end
            WB: begin
                wb_rd   = rd_r;
                wb_data = rdata_r;
                // flush only drops the register write; the csr side already committed.
                if ((rd_r != 5'd0) && !flush) begin
                    wb_valid = 1'b1;
                end else begin
                    wb_valid = 1'b0;
                end
                next_state_s = IDLE;
            end
            WAIT_TRAP: begin
                if (trap_en) begin
                    redirect_en  = 1'b1;
                    redirect_pc  = trap_pc;
                    next_state_s = IDLE;
                end else if (to_expired_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_TRAP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

endmodule
